// File: rtl/ifu_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ifu_fetch_pkg
// Purpose : Shared types and constants for the instruction-fetch stage.
//           State encoding (3-bit), reset PC, XLEN and the canonical NOP
//           encoding used by benches.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package ifu_fetch_pkg;

  localparam int unsigned IFU_XLEN     = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  typedef enum logic [2:0] {
    IFU_IDLE  = 3'd0,
    IFU_REQ   = 3'd1,
    IFU_WAIT  = 3'd2,
    IFU_HOLD  = 3'd3,
    IFU_FAULT = 3'd4
  } ifu_state_e;

  // Instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return lsbs != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module  : ifu_fetch
// Purpose : Instruction-fetch stage. Owns the PC, issues one imem request per
//           instruction, buffers the returned word and hands {instr, pc} to
//           decode. Redirects from execute retarget the PC; a redirect that
//           lands while a fetch is in flight is remembered and the stale
//           response is discarded.
// Ports   :
//   clk, rst              clock, asynchronous active-high reset
//   imem_req_valid/ready  fetch request handshake, imem_req_addr == pc
//   imem_rsp_valid/data/err  one-cycle response pulse, err = access fault
//   id_valid/ready        decode handshake, id_instr/id_pc payload
//   redirect_valid/pc     one-cycle redirect from execute
//   fetch_fault           sticky fault flag (absorbing until reset)
// Revision: 1.0 - initial release
// ============================================================================
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned         XLEN     = IFU_XLEN,
  parameter logic [XLEN-1:0]     RESET_PC = IFU_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_buf_q, instr_buf_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            w_misaligned;

  assign w_misaligned = redirect_valid && is_misaligned(redirect_pc[1:0]);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_buf_d = instr_buf_q;
    pend_d      = pend_q;
    pend_pc_d   = pend_pc_q;

    unique case (state_q)
      IFU_IDLE: begin
        state_d = IFU_REQ;
        if (redirect_valid) pc_d = redirect_pc;
      end

      IFU_REQ: begin
        // The request address must not move under backpressure, so a
        // redirect here is parked and applied once the response returns.
        if (redirect_valid) begin
          pend_d    = 1'b1;
          pend_pc_d = redirect_pc;
        end
        if (imem_req_ready) state_d = IFU_WAIT;
      end

      IFU_WAIT: begin
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            state_d = IFU_FAULT;
          end else if (redirect_valid || pend_q) begin
            // Stale word: drop it and refetch from the newest target.
            pc_d    = redirect_valid ? redirect_pc : pend_pc_q;
            pend_d  = 1'b0;
            state_d = IFU_REQ;
          end else begin
            instr_buf_d = imem_rsp_data;
            state_d     = IFU_HOLD;
          end
        end else if (redirect_valid) begin
          pend_d    = 1'b1;
          pend_pc_d = redirect_pc;
        end
      end

      IFU_HOLD: begin
        // Redirect wins over decode consuming the buffered word.
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = IFU_REQ;
        end else if (id_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = IFU_REQ;
        end
      end

      IFU_FAULT: begin
        state_d = IFU_FAULT;
      end

      default: begin
        state_d = IFU_FAULT;
      end
    endcase

    // A misaligned target faults from any live state; the target is kept
    // in pc so it can be inspected after the fault.
    if (w_misaligned && (state_q != IFU_FAULT)) begin
      state_d = IFU_FAULT;
      pc_d    = redirect_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IFU_IDLE;
      pc_q        <= RESET_PC;
      instr_buf_q <= '0;
      pend_q      <= 1'b0;
      pend_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_buf_q <= instr_buf_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
    end
  end

  // Outputs decode straight from registers, so they never depend
  // combinationally on inputs.
  assign imem_req_valid = (state_q == IFU_REQ);
  assign imem_req_addr  = pc_q;
  assign id_valid       = (state_q == IFU_HOLD);
  assign id_instr       = instr_buf_q;
  assign id_pc          = pc_q;
  assign fetch_fault    = (state_q == IFU_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_ifu_fetch
// Purpose : Self-checking bench for ifu_fetch: directed scenarios followed by
//           randomized traffic, all compared each cycle against a flag-based
//           reference model of the fetch pipeline.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  ifu_fetch #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: independent activity flags rather than a state enum.
  bit          m_fault, m_dead, m_req, m_inflight, m_stale, m_hold;
  logic [31:0] m_pc, m_stale_pc, m_buf;

  // Memory model.
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_word;
  bit          mem_err;
  bit          rand_mem  = 1'b0;
  int          cfg_delay = 0;
  logic [31:0] next_word = INST_NOP;
  bit          next_err  = 1'b0;
  bit          spurious  = 1'b0;
  int          idv_seen  = 0;
  int          req_seen  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fault = 0; m_dead = 1; m_req = 0; m_inflight = 0; m_stale = 0; m_hold = 0;
    m_pc = 32'h8000_0000; m_stale_pc = '0; m_buf = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit mis, rsp_now;
    if (m_fault) return;
    mis     = redirect_valid && (redirect_pc[1:0] != 2'b00);
    rsp_now = m_inflight && imem_rsp_valid;
    if (mis || (rsp_now && imem_rsp_err)) begin
      if (mis) m_pc = redirect_pc;
      m_fault = 1; m_dead = 0; m_req = 0; m_inflight = 0; m_hold = 0; m_stale = 0;
      return;
    end
    if (m_dead) begin
      m_dead = 0; m_req = 1;
      if (redirect_valid) m_pc = redirect_pc;
    end else if (m_req) begin
      if (redirect_valid) begin m_stale = 1; m_stale_pc = redirect_pc; end
      if (imem_req_ready) begin m_req = 0; m_inflight = 1; end
    end else if (m_inflight) begin
      if (imem_rsp_valid) begin
        m_inflight = 0;
        if (redirect_valid) begin
          m_pc = redirect_pc; m_stale = 0; m_req = 1;
        end else if (m_stale) begin
          m_pc = m_stale_pc; m_stale = 0; m_req = 1;
        end else begin
          m_buf = imem_rsp_data; m_hold = 1;
        end
      end else if (redirect_valid) begin
        m_stale = 1; m_stale_pc = redirect_pc;
      end
    end else if (m_hold) begin
      if (redirect_valid) begin
        m_pc = redirect_pc; m_hold = 0; m_req = 1;
      end else if (id_ready) begin
        m_pc = m_pc + 32'd4; m_hold = 0; m_req = 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk1("req_valid", imem_req_valid, m_req);
    chk1("id_valid", id_valid, m_hold);
    chk1("fetch_fault", fetch_fault, m_fault);
    if (m_req) chk("req_addr", imem_req_addr, m_pc);
    if (m_hold) begin
      chk("id_pc", id_pc, m_pc);
      chk("id_instr", id_instr, m_buf);
    end
  endtask

  // One clock: drive memory response, check, step model, clock.
  task automatic cyc();
    if (spurious || (mem_busy && mem_cnt == 0)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = spurious ? $urandom : mem_word;
      imem_rsp_err   = spurious ? 1'b0 : mem_err;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      imem_rsp_err   = 1'b0;
    end
    spurious = 1'b0;
    check_outputs();
    if (id_valid) idv_seen++;
    if (imem_req_valid) req_seen++;
    model_step();
    if (mem_busy) begin
      if (mem_cnt == 0) mem_busy = 0;
      else mem_cnt--;
    end
    if (imem_req_valid && imem_req_ready && !mem_busy) begin
      mem_busy = 1;
      mem_cnt  = rand_mem ? $urandom_range(0, 3) : cfg_delay;
      mem_word = rand_mem ? $urandom : next_word;
      mem_err  = next_err;
      next_err = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_id_valid", id_valid, 1'b0);
    chk1("rst_fault", fetch_fault, 1'b0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_pc", id_pc, 32'h8000_0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    mem_busy = 0;
  endtask

  function automatic bit model_cond(input int sel);
    case (sel)
      0:       return m_req;
      1:       return m_hold;
      2:       return m_inflight;
      default: return m_fault;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string tag);
    int n = 0;
    while (!model_cond(sel) && n < 40) begin
      cyc();
      n++;
    end
    checks++;
    assert (model_cond(sel)) else begin
      failures++;
      $error("FAIL wait_%s observed=timeout expected=reached", tag);
    end
  endtask

  initial begin
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    model_reset();
    #1;
    do_reset();

    // Basic fetch with zero-delay memory.
    cfg_delay = 0;
    next_word = 32'h0010_0093;
    wait_for(1, "t1_hold");
    chk("t1_id_pc", id_pc, 32'h8000_0000);
    chk("t1_id_instr", id_instr, 32'h0010_0093);
    cyc();
    chk1("t1_next_req", imem_req_valid, 1'b1);
    chk("t1_next_addr", imem_req_addr, 32'h8000_0004);

    // Decode stall for 5 cycles.
    next_word = INST_NOP;
    id_ready  = 1'b0;
    wait_for(1, "t2_hold");
    req_seen = 0;
    for (int k = 0; k < 5; k++) begin
      chk1("t2_stall_valid", id_valid, 1'b1);
      chk("t2_stall_instr", id_instr, INST_NOP);
      chk("t2_stall_pc", id_pc, 32'h8000_0004);
      cyc();
    end
    chk("t2_no_req", 32'(req_seen), 32'd0);
    id_ready = 1'b1;
    cyc();
    chk("t2_next_addr", imem_req_addr, 32'h8000_0008);

    // Redirect while waiting for a slow response.
    cfg_delay = 3;
    wait_for(2, "t3_inflight");
    idv_seen       = 0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    cyc();
    redirect_valid = 1'b0;
    wait_for(0, "t3_req");
    chk("t3_no_id_valid", 32'(idv_seen), 32'd0);
    chk("t3_addr", imem_req_addr, 32'h8000_0100);

    // Redirect coincident with id_ready in HOLD.
    cfg_delay = 0;
    id_ready  = 1'b0;
    wait_for(1, "t4_hold");
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    cyc();
    redirect_valid = 1'b0;
    chk1("t4_req", imem_req_valid, 1'b1);
    chk("t4_addr", imem_req_addr, 32'h8000_0200);

    // Memory backpressure with a redirect on the second stalled cycle.
    cfg_delay      = 1;
    imem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      redirect_valid = (k == 1);
      redirect_pc    = 32'h8000_0040;
      chk("t5_stable_addr", imem_req_addr, 32'h8000_0200);
      cyc();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    idv_seen       = 0;
    cyc();
    wait_for(0, "t5_req");
    chk("t5_no_id_valid", 32'(idv_seen), 32'd0);
    chk("t5_addr", imem_req_addr, 32'h8000_0040);

    // PC wrap at the top of the address space.
    id_ready = 1'b0;
    wait_for(1, "t6_hold");
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    wait_for(1, "t6_hold2");
    chk("t6_pc_top", id_pc, 32'hFFFF_FFFC);
    id_ready = 1'b1;
    cyc();
    chk("t6_wrap_addr", imem_req_addr, 32'h0000_0000);

    // Randomized traffic with one mid-operation reset.
    rand_mem = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
      cyc();
      if (i == 700) begin
        redirect_valid = 1'b0;
        do_reset();
        spurious = 1'b1;
      end
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;

    // Misaligned redirect -> sticky fault.
    do_reset();
    wait_for(0, "f1_req");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0002;
    cyc();
    redirect_valid = 1'b0;
    chk1("f1_fault", fetch_fault, 1'b1);
    chk("f1_pc_kept", id_pc, 32'h8000_0002);
    req_seen = 0;
    for (int k = 0; k < 20; k++) begin
      redirect_valid = (k == 5);
      redirect_pc    = 32'h8000_0300;
      cyc();
    end
    redirect_valid = 1'b0;
    chk("f1_no_req", 32'(req_seen), 32'd0);
    chk1("f1_still_fault", fetch_fault, 1'b1);

    // Access fault on the response.
    do_reset();
    rand_mem  = 1'b0;
    cfg_delay = 1;
    next_err  = 1'b1;
    wait_for(3, "f2_fault");
    chk1("f2_fault", fetch_fault, 1'b1);
    req_seen = 0;
    repeat (10) cyc();
    chk("f2_no_req", 32'(req_seen), 32'd0);
    chk1("f2_still_fault", fetch_fault, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch stage of the NPC core; sits directly upstream of the decoder.
- Owns the PC and issues one fetch per instruction to instruction memory over a valid/ready request plus a valid response channel.
- Buffers the returned word and presents {instr, pc} to decode with a valid/ready handshake.
- Accepts redirects (jumps, branches) from execute and discards stale fetches.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- XLEN, 32, address and instruction width. Only 32 is supported.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  fetch address; always equals pc.
- imem_rsp_valid  in  1  response valid, one-cycle pulse.
- imem_rsp_data  in  32  fetched instruction word.
- imem_rsp_err  in  1  access fault, qualified by imem_rsp_valid.
- id_valid  out  1  instr/pc valid to decode.
- id_ready  in  1  decode consumes the instruction.
- id_instr  out  32  buffered instruction.
- id_pc  out  32  PC of id_instr.
- redirect_valid  in  1  one-cycle redirect from execute.
- redirect_pc  in  32  redirect target.
- fetch_fault  out  1  sticky fault flag.

Behaviour:
- States: IDLE, REQ, WAIT, HOLD, FAULT. pc and instr_buf are registers; the pending-redirect flag pend and its target pend_pc are registers.
- Reset (async, rst=1): state=IDLE, pc=RESET_PC, pend=0, instr_buf=0.
  - Outputs during reset: imem_req_valid=0, id_valid=0, fetch_fault=0, id_instr=0, id_pc=RESET_PC.
- Reset mid-operation:
  - An outstanding request is abandoned; any response arriving in IDLE is ignored.
  - The imem model must tolerate this.
- IDLE: always moves to REQ next cycle. This gives one dead cycle after reset release.
- REQ:
  - Drives imem_req_valid=1, imem_req_addr=pc.
  - addr must stay stable while valid && !ready.
  - req_valid && req_ready -> WAIT.
- Redirect in REQ without handshake:
  - Sets pend=1, pend_pc=redirect_pc.
  - The current request completes unchanged and its response is later discarded.
- Redirect in the same cycle as the handshake: treated identically (pend=1, then WAIT).
- WAIT: holds until imem_rsp_valid. Three outcomes:
  - rsp_err=1, regardless of pend: -> FAULT.
  - Discard case (pend=1, or redirect_valid this cycle): drop the word, pc<=target, pend<=0, -> REQ. Target is the current-cycle redirect_pc if redirect_valid, otherwise pend_pc.
  - Otherwise: instr_buf<=rsp_data, -> HOLD.
- Latency: id_valid rises the cycle after the response; minimum 3 cycles per instruction (REQ, WAIT with same-cycle response, HOLD).
- HOLD:
  - Drives id_valid=1, id_instr=instr_buf, id_pc=pc.
  - Outputs stay stable until id_ready.
  - id_ready && !redirect_valid: pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC -> 0), -> REQ.
- Redirect in HOLD: has priority over id_ready. The buffered instruction is dropped (even if id_ready=1), pc<=redirect_pc, -> REQ. id_valid falls next cycle.
- Misaligned redirect (redirect_pc[1:0]!=0) in any state:
  - -> FAULT next cycle.
  - The target is still recorded in pc for debug.
  - No further requests are issued; an in-flight response is ignored.
- FAULT:
  - fetch_fault=1 and all valids 0.
  - Absorbing; only rst exits.
- Simultaneous events: rst dominates everything; fault dominates redirect; redirect dominates id_ready and the response.
- Redirect in IDLE: pc<=redirect_pc, -> REQ.
- Multiple redirects while pend=1: the last one wins.

Decomposition:
- Shared defines file additions:
  - IFU state encodings (`IFU_IDLE, `IFU_REQ, `IFU_WAIT, `IFU_HOLD, `IFU_FAULT, 3-bit).
  - `RESET_PC.
  - `INST_NOP (32'h0000_0013) for bench use.
- No sub-module. The pc/pend update logic is a single always block plus one next-state block.

Test Plan:
- Reset then imem_req_ready=1 and a zero-delay response of 0x00100093 at 0x80000000, id_ready=1 -> id_valid with id_pc=0x80000000, id_instr=0x00100093; next request addr=0x80000004.
- Decode stall: id_ready=0 for 5 cycles in HOLD -> id_valid, id_instr and id_pc stable for all 5 cycles, no new imem request; id_ready=1 -> request to pc+4.
- Redirect to 0x80000100 while in WAIT, response arrives 3 cycles later -> word discarded, id_valid never asserted for it, next request addr=0x80000100.
- Redirect to 0x80000200 in the same cycle as id_ready in HOLD -> next request addr=0x80000200 (not pc+4).
- Memory backpressure (req_ready=0 for 4 cycles) with a redirect to 0x80000040 on cycle 2 -> addr stays at the original pc until accepted; response discarded; next request addr=0x80000040.
- Fault paths:
  - redirect_pc=0x80000002 -> fetch_fault=1 next cycle and stays 1, no requests until rst.
  - rsp_err=1 -> same result.
